// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//   Three-channel PWM generator (red/green/blue) with an optional linear fader
//   that walks each channel's duty one step at a time toward a requested target.
//
//   Build option: define RGB_PWM_FADER_FADE_EN to compile in the fader. Without
//   it, target_load copies the targets straight into the duties and busy is 0.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   ena           in   count enable; when low the PWM outputs drop to 0 and all
//                      timers freeze (target_load is still accepted)
//   target_load   in   one-cycle strobe: accept target_r/g/b
//   target_r/g/b  in   requested duties, PWM_WIDTH bits each
//   rgb_pwm       out  active-high PWM, bit0 red, bit1 green, bit2 blue
//   busy          out  high while fading toward a target
//   period_start  out  one-cycle pulse at the start of each PWM period
module rgb_pwm_fader #(
    parameter int CLK_HZ         = 12_000_000,
    parameter int PWM_PERIOD_US  = 100,
    parameter int PWM_WIDTH      = 4,
    parameter int PERIOD_MS_FADE = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 target_load,
    input  logic [PWM_WIDTH-1:0] target_r,
    input  logic [PWM_WIDTH-1:0] target_g,
    input  logic [PWM_WIDTH-1:0] target_b,
    output logic [2:0]           rgb_pwm,
    output logic                 busy,
    output logic                 period_start
);

    // 64-bit arithmetic so CLK_HZ * PWM_PERIOD_US cannot overflow.
    localparam longint PWM_TICKS    = longint'(CLK_HZ) * longint'(PWM_PERIOD_US) / 64'd1_000_000;
    localparam longint PRESCALE_RAW = PWM_TICKS >> PWM_WIDTH;
    localparam int     PRESCALE     = (PRESCALE_RAW < 1) ? 1 : int'(PRESCALE_RAW);
    localparam int     PS_W         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]      PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] PH_MAX = '1;

    localparam longint FADE_RAW        = (longint'(CLK_HZ) / 1000 * longint'(PERIOD_MS_FADE)) >> PWM_WIDTH;
    localparam int     FADE_STEP_TICKS = (FADE_RAW < 1) ? 1 : int'(FADE_RAW);

    logic [PS_W-1:0]              presc_q;
    logic [PWM_WIDTH-1:0]         phase_q;
    logic [2:0]                   rgb_q;
    logic                         ps_q;
    logic [2:0][PWM_WIDTH-1:0]    duty_q;
    logic [2:0][PWM_WIDTH-1:0]    tgt_in;
    logic                         presc_wrap;

    assign tgt_in     = {target_b, target_g, target_r};
    assign presc_wrap = ena && (presc_q == PS_MAX);

    // PWM timebase and comparator
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= '0;
            rgb_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            if (ena) presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) phase_q <= phase_q + 1'b1;
            // Registered alongside the 15->0 phase wrap, so the pulse is
            // visible in the first cycle of phase 0.
            ps_q <= presc_wrap && (phase_q == PH_MAX);
            for (int c = 0; c < 3; c++)
                rgb_q[c] <= ena && (phase_q < duty_q[c]);
        end
    end

    assign rgb_pwm      = rgb_q;
    assign period_start = ps_q;

`ifdef RGB_PWM_FADER_FADE_EN
    localparam int FT_W = $clog2((FADE_STEP_TICKS > 1) ? FADE_STEP_TICKS : 2);
    localparam logic [FT_W-1:0] FT_MAX = FT_W'(FADE_STEP_TICKS - 1);

    typedef enum logic {IDLE, FADING} state_e;

    state_e                    state_q;
    logic [2:0][PWM_WIDTH-1:0] tgt_q;
    logic [FT_W-1:0]           ftmr_q;
    logic [2:0][PWM_WIDTH-1:0] step_d;
    logic                      fade_tick;

    assign fade_tick = (state_q == FADING) && ena && (ftmr_q == FT_MAX);

    // One unsigned step toward each target; equal channels stay put.
    always_comb begin
        step_d = duty_q;
        for (int c = 0; c < 3; c++) begin
            if (duty_q[c] < tgt_q[c])      step_d[c] = duty_q[c] + 1'b1;
            else if (duty_q[c] > tgt_q[c]) step_d[c] = duty_q[c] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            duty_q  <= '0;
            ftmr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (target_load) begin
                        tgt_q <= tgt_in;
                        if (tgt_in != duty_q) begin
                            state_q <= FADING;
                            ftmr_q  <= '0;
                        end
                    end
                end
                FADING: begin
                    // Retargeting keeps the timer running; a load that lands on
                    // a tick suppresses that tick's step.
                    if (ena) ftmr_q <= fade_tick ? '0 : ftmr_q + 1'b1;
                    if (target_load) begin
                        tgt_q <= tgt_in;
                    end else begin
                        if (fade_tick) duty_q <= step_d;
                        if (duty_q == tgt_q) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == FADING);
`else
    always_ff @(posedge clk) begin
        if (rst)              duty_q <= '0;
        else if (target_load) duty_q <= tgt_in;
    end

    // Always 0: the step period is clamped to at least one tick.
    assign busy = (FADE_STEP_TICKS == 0);
`endif

endmodule

// File: tb/tb_rgb_pwm_fader.sv
module tb_rgb_pwm_fader;
    logic       clk = 1'b0;
    logic       rst, ena, target_load;
    logic [3:0] t_r, t_g, t_b;
    logic [2:0] rgb_pwm;
    logic       busy, period_start;

    int checks   = 0;
    int failures = 0;

    rgb_pwm_fader #(
        .CLK_HZ(1_000_000), .PWM_PERIOD_US(64), .PWM_WIDTH(4), .PERIOD_MS_FADE(1)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .target_load(target_load),
        .target_r(t_r), .target_g(t_g), .target_b(t_b),
        .rgb_pwm(rgb_pwm), .busy(busy), .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r, g, b;
        int         er, eg, eb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        t_r = r; t_g = g; t_b = b;
        target_load = 1'b1;
        tick();
        target_load = 1'b0;
    endtask

    // High-cycle counts over one full 64-cycle window.
    task automatic count_window(output int hr, output int hg, output int hb, output int hp);
        hr = 0; hg = 0; hb = 0; hp = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            hr += int'(rgb_pwm[0]);
            hg += int'(rgb_pwm[1]);
            hb += int'(rgb_pwm[2]);
            hp += int'(period_start);
        end
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 300);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 0);
    endtask

`ifdef RGB_PWM_FADER_FADE_EN
    task automatic wait_duty(output int n);
        logic [3:0] prev;
        prev = dut.duty_q[0];
        n = 0;
        do begin
            tick();
            n++;
        end while (dut.duty_q[0] == prev && n < 300);
    endtask
`endif

    initial begin
        vec_t vecs[5];
        int   hr, hg, hb, hp, n, bad;

        vecs[0] = '{r: 4'd8,  g: 4'd0,  b: 4'd15, er: 32, eg: 0,  eb: 60};
        vecs[1] = '{r: 4'd1,  g: 4'd2,  b: 4'd3,  er: 4,  eg: 8,  eb: 12};
        vecs[2] = '{r: 4'd15, g: 4'd15, b: 4'd15, er: 60, eg: 60, eb: 60};
        vecs[3] = '{r: 4'd0,  g: 4'd0,  b: 4'd0,  er: 0,  eg: 0,  eb: 0};
        vecs[4] = '{r: 4'd7,  g: 4'd12, b: 4'd5,  er: 28, eg: 48, eb: 20};

        // Reset overrides ena and target_load.
        rst = 1'b1; ena = 1'b1; target_load = 1'b1;
        t_r = 4'd5; t_g = 4'd6; t_b = 4'd7;
        repeat (3) tick();
        check("rst_during_rgb",  {29'd0, rgb_pwm}, 0);
        check("rst_during_busy", {31'd0, busy}, 0);
        check("rst_during_ps",   {31'd0, period_start}, 0);
        rst = 1'b0; target_load = 1'b0;
        tick();
        check("rst_after_rgb",  {29'd0, rgb_pwm}, 0);
        check("rst_after_busy", {31'd0, busy}, 0);
        check("rst_after_ps",   {31'd0, period_start}, 0);
        count_window(hr, hg, hb, hp);
        check("rst_duty_clear", hr + hg + hb, 0);

`ifndef RGB_PWM_FADER_FADE_EN
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].r, vecs[i].g, vecs[i].b);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 0);
            tick(); tick();
            count_window(hr, hg, hb, hp);
            check($sformatf("vec%0d_red", i),   hr, vecs[i].er);
            check($sformatf("vec%0d_green", i), hg, vecs[i].eg);
            check($sformatf("vec%0d_blue", i),  hb, vecs[i].eb);
            check($sformatf("vec%0d_ps", i),    hp, 1);
        end
        wait_ps(n);
        wait_ps(n);
        check("ps_interval", n, 64);
`else
        // Fade 0 -> 4 on red: one step every 62 cycles.
        load(4'd4, 4'd0, 4'd0);
        check("fade_busy_rise", {31'd0, busy}, 1);
        for (int k = 1; k <= 4; k++) begin
            wait_duty(n);
            check($sformatf("fade_up_int%0d", k), n, 62);
            check($sformatf("fade_up_val%0d", k), {28'd0, dut.duty_q[0]}, k);
        end
        check("fade_busy_at4", {31'd0, busy}, 1);
        tick();
        check("fade_busy_fall", {31'd0, busy}, 0);

        // 10 -> 2, retarget to 9 at duty 6 without restarting the timer.
        load(4'd10, 4'd0, 4'd0);
        wait_idle();
        check("retgt_start", {28'd0, dut.duty_q[0]}, 10);
        load(4'd2, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) wait_duty(n);
        check("retgt_at6", {28'd0, dut.duty_q[0]}, 6);
        repeat (20) tick();
        load(4'd9, 4'd0, 4'd0);
        wait_duty(n);
        check("retgt_int7", n, 41);
        check("retgt_val7", {28'd0, dut.duty_q[0]}, 7);
        for (int k = 8; k <= 9; k++) begin
            wait_duty(n);
            check($sformatf("retgt_int%0d", k), n, 62);
            check($sformatf("retgt_val%0d", k), {28'd0, dut.duty_q[0]}, k);
        end
        repeat (200) tick();
        check("retgt_no_overshoot", {28'd0, dut.duty_q[0]}, 9);
        check("retgt_idle", {31'd0, busy}, 0);

        // Load landing exactly on a fade tick: no step that cycle.
        load(4'd13, 4'd0, 4'd0);
        wait_duty(n);
        check("coinc_first", {28'd0, dut.duty_q[0]}, 10);
        repeat (61) tick();
        load(4'd5, 4'd0, 4'd0);
        check("coinc_nostep", {28'd0, dut.duty_q[0]}, 10);
        wait_duty(n);
        check("coinc_next_int", n, 62);
        check("coinc_next_val", {28'd0, dut.duty_q[0]}, 9);
        wait_idle();
`endif

        // ena low for 100 cycles mid-period.
        load(4'd8, 4'd0, 4'd15);
        tick();
        wait_idle();
        wait_ps(n);
        repeat (10) tick();
        ena = 1'b0;
        tick();
        check("ena_off_rgb", {29'd0, rgb_pwm}, 0);
        bad = 0;
        repeat (99) begin
            tick();
            if (rgb_pwm != 3'b000 || period_start) bad++;
        end
        check("ena_off_hold", bad, 0);
        ena = 1'b1;
        wait_ps(n);
        check("ena_resume_gap", 110 + n, 164);
        count_window(hr, hg, hb, hp);
        check("ena_resume_red",  hr, 32);
        check("ena_resume_blue", hb, 60);

        // Reset in the middle of operation (mid-fade when fading is built in).
        load(4'd3, 4'd9, 4'd12);
        repeat (70) tick();
        rst = 1'b1;
        tick();
        check("rstmid_rgb",  {29'd0, rgb_pwm}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        count_window(hr, hg, hb, hp);
        check("rstmid_clear", hr + hg + hb, 0);
        check("rstmid_busy_after", {31'd0, busy}, 0);
`ifdef RGB_PWM_FADER_FADE_EN
        repeat (200) tick();
        check("rstmid_duty", {20'd0, dut.duty_q}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
